// File: rtl/bcd_rtc_counter_pkg.sv
// Shared types, limits and BCD helpers for the bcd_rtc_counter block.
// Internal time is always 24h two-digit BCD.
package rtc_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_MAX_SS = 8'h59;
    localparam bcd2_t BCD_MAX_MM = 8'h59;
    localparam bcd2_t BCD_MAX_HH = 8'h23;
    localparam bcd2_t BCD_NOON   = 8'h12;

    // True when both nibbles are decimal digits and the value does not exceed max_v.
    function automatic logic bcd2_valid(input bcd2_t v, input bcd2_t max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    // Maps a valid 24h BCD hour onto the 12h dial (00 -> 12, 13..23 -> 01..11).
    function automatic bcd2_t bcd2_to_12h(input bcd2_t h24);
        bcd2_t h12;
        if (h24 == 8'h00)
            h12 = BCD_NOON;
        else if (h24 <= BCD_NOON)
            h12 = h24;
        else if (h24[7:4] == 4'd1)
            h12 = {4'd0, h24[3:0] - 4'd2};
        else if (h24[3:0] < 4'd2)
            h12 = {4'd0, h24[3:0] + 4'd8};
        else
            h12 = {4'd1, h24[3:0] - 4'd2};
        return h12;
    endfunction

endpackage

// File: rtl/bcd_rtc_counter_if.sv
// Signal bundle between the tick generator / CPU block and bcd_rtc_counter.
// Alarm signals exist only when BCD_RTC_ALARM_EN is defined.
interface bcd_rtc_counter_if;
    import rtc_pkg::*;

    // Handshake: tick_en, load and alarm_wr are single-cycle request pulses with
    // no ready; each is consumed at the rising edge where it is seen high.
    // Strobes and load_err are single-cycle responses aligned with the new state.
    logic  tick_en;
    logic  mode_12h;
    logic  load;
    bcd2_t load_hh;
    bcd2_t load_mm;
    bcd2_t load_ss;
    bcd2_t hh;
    bcd2_t mm;
    bcd2_t ss;
    logic  pm;
    logic  min_stb;
    logic  hour_stb;
    logic  day_stb;
    logic  load_err;

`ifdef BCD_RTC_ALARM_EN
    logic  alarm_wr;
    bcd2_t alarm_hh;
    bcd2_t alarm_mm;
    logic  alarm_irq;

    modport master (
        output tick_en, mode_12h, load, load_hh, load_mm, load_ss,
        output alarm_wr, alarm_hh, alarm_mm,
        input  hh, mm, ss, pm, min_stb, hour_stb, day_stb, load_err, alarm_irq
    );

    modport slave (
        input  tick_en, mode_12h, load, load_hh, load_mm, load_ss,
        input  alarm_wr, alarm_hh, alarm_mm,
        output hh, mm, ss, pm, min_stb, hour_stb, day_stb, load_err, alarm_irq
    );
`else
    modport master (
        output tick_en, mode_12h, load, load_hh, load_mm, load_ss,
        input  hh, mm, ss, pm, min_stb, hour_stb, day_stb, load_err
    );

    modport slave (
        input  tick_en, mode_12h, load, load_hh, load_mm, load_ss,
        output hh, mm, ss, pm, min_stb, hour_stb, day_stb, load_err
    );
`endif

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at limit_i, with synchronous load and a
// carry that flags the increment which wraps limit_i back to 00.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter bcd2_t RESET_VAL = 8'h00
) (
    input  logic  clk,
    input  logic  reset,
    input  bcd2_t limit_i,
    input  logic  inc_i,
    input  logic  load_i,
    input  bcd2_t load_val_i,
    output bcd2_t count_o,
    output logic  carry_o
);

    bcd2_t count_q;
    bcd2_t count_d;
    logic  at_limit;

    assign at_limit = (count_q == limit_i);
    assign carry_o  = inc_i & ~load_i & at_limit;
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            if (at_limit)
                count_d = 8'h00;
            else if (count_q[3:0] == 4'd9)
                count_d = {count_q[7:4] + 4'd1, 4'd0};
            else
                count_d = {count_q[7:4], count_q[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= RESET_VAL;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/bcd_rtc_counter.sv
// BCD hh:mm:ss real-time counter advanced by a prescaled tick enable, with
// validated loads, rollover strobes and 12/24h display. Alarm: BCD_RTC_ALARM_EN.
module bcd_rtc_counter
    import rtc_pkg::*;
#(
    parameter int    TICK_DIV = 1,
    parameter bcd2_t RESET_HH = 8'h00
) (
    input logic              clk,
    input logic              reset,
    bcd_rtc_counter_if.slave bus
);

    localparam int            PW         = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          load_ok;
    logic          load_acc;
    logic          load_rej;
    logic          alarm_rej;
    logic          advance;
    logic          ss_carry;
    logic          mm_carry;
    logic          hh_carry;
    bcd2_t         ss_q;
    bcd2_t         mm_q;
    bcd2_t         hh24_q;
    logic          min_stb_q;
    logic          hour_stb_q;
    logic          day_stb_q;
    logic          load_err_q;
    bcd2_t         hh_disp;
    logic          pm_disp;

    assign load_ok  = bcd2_valid(bus.load_hh, BCD_MAX_HH) &&
                      bcd2_valid(bus.load_mm, BCD_MAX_MM) &&
                      bcd2_valid(bus.load_ss, BCD_MAX_SS);
    assign load_acc = bus.load & load_ok;
    assign load_rej = bus.load & ~load_ok;

    // Any load request, accepted or not, swallows a coincident tick.
    assign advance  = bus.tick_en & ~bus.load & (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (bus.load) begin
            if (load_ok)
                presc_d = '0;
        end else if (bus.tick_en) begin
            if (presc_q == PRESC_LAST)
                presc_d = '0;
            else
                presc_d = presc_q + PW'(1);
        end
    end

    bcd_mod_counter #(.RESET_VAL(8'h00)) u_ss (
        .clk        (clk),
        .reset      (reset),
        .limit_i    (BCD_MAX_SS),
        .inc_i      (advance),
        .load_i     (load_acc),
        .load_val_i (bus.load_ss),
        .count_o    (ss_q),
        .carry_o    (ss_carry)
    );

    bcd_mod_counter #(.RESET_VAL(8'h00)) u_mm (
        .clk        (clk),
        .reset      (reset),
        .limit_i    (BCD_MAX_MM),
        .inc_i      (ss_carry),
        .load_i     (load_acc),
        .load_val_i (bus.load_mm),
        .count_o    (mm_q),
        .carry_o    (mm_carry)
    );

    bcd_mod_counter #(.RESET_VAL(RESET_HH)) u_hh (
        .clk        (clk),
        .reset      (reset),
        .limit_i    (BCD_MAX_HH),
        .inc_i      (mm_carry),
        .load_i     (load_acc),
        .load_val_i (bus.load_hh),
        .count_o    (hh24_q),
        .carry_o    (hh_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            min_stb_q  <= 1'b0;
            hour_stb_q <= 1'b0;
            day_stb_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            min_stb_q  <= ss_carry;
            hour_stb_q <= mm_carry;
            day_stb_q  <= hh_carry;
            load_err_q <= load_rej | alarm_rej;
        end
    end

    always_comb begin
        hh_disp = hh24_q;
        pm_disp = 1'b0;
        if (bus.mode_12h) begin
            hh_disp = bcd2_to_12h(hh24_q);
            pm_disp = (hh24_q >= BCD_NOON);
        end
    end

    assign bus.hh       = hh_disp;
    assign bus.mm       = mm_q;
    assign bus.ss       = ss_q;
    assign bus.pm       = pm_disp;
    assign bus.min_stb  = min_stb_q;
    assign bus.hour_stb = hour_stb_q;
    assign bus.day_stb  = day_stb_q;
    assign bus.load_err = load_err_q;

`ifdef BCD_RTC_ALARM_EN
    bcd2_t alarm_hh_q;
    bcd2_t alarm_mm_q;
    logic  armed_q;
    logic  adv_q;
    logic  alarm_ok;

    assign alarm_ok  = bcd2_valid(bus.alarm_hh, BCD_MAX_HH) &&
                       bcd2_valid(bus.alarm_mm, BCD_MAX_MM);
    assign alarm_rej = bus.alarm_wr & ~alarm_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_hh_q <= 8'h00;
            alarm_mm_q <= 8'h00;
            armed_q    <= 1'b0;
            adv_q      <= 1'b0;
        end else begin
            adv_q <= advance;
            if (bus.alarm_wr && alarm_ok) begin
                alarm_hh_q <= bus.alarm_hh;
                alarm_mm_q <= bus.alarm_mm;
                armed_q    <= 1'b1;
            end
        end
    end

    // adv_q marks the one cycle after a real advance, so a load onto the alarm time never fires.
    assign bus.alarm_irq = armed_q & adv_q & (hh24_q == alarm_hh_q) &
                           (mm_q == alarm_mm_q) & (ss_q == 8'h00);
`else
    assign alarm_rej = 1'b0;
`endif

endmodule
